// File: rtl/key_sched.sv
// -----------------------------------------------------------------------------
// key_sched : iterative round-key generator.
//
// A master key of four DATAW-bit words (k0..k3) is captured on load. The
// schedule then emits one round key per accepted handshake: rk is always the
// oldest word k0. On every non-final handshake the four-word window slides
// down by one and a freshly mixed word enters at k3. A 5-bit LFSR supplies one
// round-constant bit per step. After NROUNDS keys the block returns to idle
// and pulses done.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   load      in   capture key and start a schedule (honoured only in IDLE)
//   key       in   master key {k3, k2, k1, k0}, 4*DATAW bits
//   rk        out  current round key (k0)
//   rk_valid  out  rk is valid (high throughout RUN)
//   rk_ready  in   consumer accepts rk this cycle
//   rk_idx    out  round number of rk
//   rk_last   out  rk_valid and rk_idx == NROUNDS-1
//   busy      out  schedule in progress
//   done      out  one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module key_sched #(
  parameter int DATAW   = 10,
  parameter int NROUNDS = 32,
  parameter int ROUNDW  = 5   // must satisfy 2**ROUNDW >= NROUNDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [4*DATAW-1:0]   key,
  output logic [DATAW-1:0]     rk,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [ROUNDW-1:0]    rk_idx,
  output logic                 rk_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ROUNDW-1:0] C_LAST      = ROUNDW'(NROUNDS - 1);
  localparam logic [4:0]        C_LFSR_SEED = 5'b00001;
  localparam logic [DATAW-1:0]  C_RCON      = DATAW'(3);

  // Rotate right by a constant amount, done by shifting a doubled copy.
  function automatic logic [DATAW-1:0] rotr(input logic [DATAW-1:0] x,
                                            input int unsigned      n);
    logic [2*DATAW-1:0] dbl;
    dbl = {x, x} >> n;
    return dbl[DATAW-1:0];
  endfunction

  // Mixing function producing the word that enters at k3.
  function automatic logic [DATAW-1:0] next_word(input logic [DATAW-1:0] k0,
                                                 input logic [DATAW-1:0] k1,
                                                 input logic [DATAW-1:0] k3,
                                                 input logic             lfsr_b0);
    logic [DATAW-1:0] t;
    logic [DATAW-1:0] z;
    t = rotr(k3, 3) ^ k1;
    z = {{(DATAW-1){1'b0}}, lfsr_b0};
    return (~k0) ^ t ^ rotr(t, 1) ^ z ^ C_RCON;
  endfunction

  // Fibonacci-style 5-bit LFSR step (taps on bits 4 and 2).
  function automatic logic [4:0] lfsr_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  state_t              r_state;
  logic [DATAW-1:0]    r_k0;
  logic [DATAW-1:0]    r_k1;
  logic [DATAW-1:0]    r_k2;
  logic [DATAW-1:0]    r_k3;
  logic [ROUNDW-1:0]   r_cnt;
  logic [4:0]          r_lfsr;
  logic                r_last;
  logic                r_done;

  logic [DATAW-1:0]    w_new;
  logic                w_hs;
  logic                w_final;

  // Next schedule word and handshake qualifiers.
  always_comb begin
    w_new   = next_word(r_k0, r_k1, r_k3, r_lfsr[0]);
    w_hs    = (r_state == ST_RUN) && rk_ready;
    w_final = w_hs && (r_cnt == C_LAST);
  end

  // Schedule FSM with key window, round counter, LFSR and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k0    <= {DATAW{1'b0}};
      r_k1    <= {DATAW{1'b0}};
      r_k2    <= {DATAW{1'b0}};
      r_k3    <= {DATAW{1'b0}};
      r_cnt   <= {ROUNDW{1'b0}};
      r_lfsr  <= C_LFSR_SEED;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_k0    <= key[DATAW-1:0];
            r_k1    <= key[2*DATAW-1:DATAW];
            r_k2    <= key[3*DATAW-1:2*DATAW];
            r_k3    <= key[4*DATAW-1:3*DATAW];
            r_cnt   <= {ROUNDW{1'b0}};
            r_lfsr  <= C_LFSR_SEED;
            // Single-round configurations are last from the first key.
            r_last  <= (C_LAST == {ROUNDW{1'b0}});
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_final) begin
            // Window and counter hold; only the status changes.
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_hs) begin
            r_k0   <= r_k1;
            r_k1   <= r_k2;
            r_k2   <= r_k3;
            r_k3   <= w_new;
            r_cnt  <= r_cnt + ROUNDW'(1);
            r_lfsr <= lfsr_step(r_lfsr);
            r_last <= ((r_cnt + ROUNDW'(1)) == C_LAST);
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign rk       = r_k0;
  assign rk_idx   = r_cnt;
  assign rk_valid = (r_state == ST_RUN);
  assign busy     = (r_state == ST_RUN);
  assign rk_last  = r_last;
  assign done     = r_done;

endmodule

// File: tb/tb_key_sched.sv
// -----------------------------------------------------------------------------
// tb_key_sched : randomized self-checking bench for key_sched.
// The expected round-key sequence for a master key is expanded up front into
// an array (sliding word recurrence plus an LFSR bit sequence) and each
// emitted rk is compared against the array entry for its round number.
// -----------------------------------------------------------------------------
module tb_key_sched;

  localparam int DW = 10;
  localparam int NR = 32;
  localparam int RW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [4*DW-1:0] key;
  logic [DW-1:0]   rk;
  logic            rk_valid;
  logic            rk_ready;
  logic [RW-1:0]   rk_idx;
  logic            rk_last;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_rk [0:NR-1];

  key_sched #(.DATAW(DW), .NROUNDS(NR), .ROUNDW(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .key      (key),
    .rk       (rk),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ror(input logic [DW-1:0] x, input int n);
    int v;
    v = int'(x);
    return DW'(((v >> n) | (v << (DW - n))) & ((1 << DW) - 1));
  endfunction

  // Expand the whole key schedule for one master key.
  function automatic void build_model(input logic [4*DW-1:0] kv);
    int            w [0:NR+3];
    int            lfsr;
    int            t;
    int            mask;
    mask = (1 << DW) - 1;
    for (int i = 0; i < 4; i++) w[i] = int'((kv >> (i * DW)) & 40'(mask));
    lfsr = 1;
    for (int i = 0; i + 4 < NR; i++) begin
      t = int'(ror(DW'(w[i + 3]), 3)) ^ w[i + 1];
      w[i + 4] = ((~w[i]) ^ t ^ int'(ror(DW'(t), 1)) ^ (lfsr & 1) ^ 3) & mask;
      lfsr = ((lfsr << 1) & 30) | (((lfsr >> 4) ^ (lfsr >> 2)) & 1);
    end
    for (int i = 0; i < NR; i++) exp_rk[i] = DW'(w[i]);
  endfunction

  // Load kv and follow the schedule; optional stall window, reset, or
  // ignored load; rnd selects random rk_ready. Ends in the done cycle
  // (or after the reset abort checks), just past a falling edge.
  task automatic run(input logic [4*DW-1:0] kv, input int stall_at, input int stall_len,
                     input int rst_at, input int load_at, input bit rnd);
    int idx     = 0;
    int cyc     = 0;
    int stalled = 0;
    bit aborted = 1'b0;
    build_model(kv);
    key      = kv;
    load     = 1'b1;
    rk_ready = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    while (idx < NR && cyc < 400) begin
      cyc++;
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == stall_at && stalled < stall_len) begin
        rk_ready = 1'b0;
        stalled++;
      end
      if (idx == load_at) begin
        load = 1'b1;
        key  = ~kv;
      end
      if (idx == rst_at) rst = 1'b1;
      @(negedge clk);
      check("rk_valid", 64'(rk_valid), 64'd1);
      check("busy",     64'(busy),     64'd1);
      check("rk",       64'(rk),       64'(exp_rk[idx]));
      check("rk_idx",   64'(rk_idx),   64'(idx));
      check("rk_last",  64'(rk_last),  64'(idx == NR - 1));
      check("done_run", 64'(done),     64'd0);
      @(posedge clk); #1;
      load = 1'b0;
      key  = kv;
      if (rst) begin
        rst     = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (rk_ready) idx++;
    end
    if (aborted) begin
      @(negedge clk);
      check("rst_valid", 64'(rk_valid), 64'd0);
      check("rst_busy",  64'(busy),     64'd0);
      check("rst_idx",   64'(rk_idx),   64'd0);
      check("rst_rk",    64'(rk),       64'd0);
      check("rst_last",  64'(rk_last),  64'd0);
      check("rst_done",  64'(done),     64'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("abort_done",  64'(done),     64'd0);
        check("abort_valid", 64'(rk_valid), 64'd0);
      end
    end else begin
      if (idx != NR) check("timeout", 64'(idx), 64'(NR));
      @(negedge clk);
      check("done_pulse", 64'(done),     64'd1);
      check("end_valid",  64'(rk_valid), 64'd0);
      check("end_busy",   64'(busy),     64'd0);
      check("end_last",   64'(rk_last),  64'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b1;
    rk_ready = 1'b1;
    key      = 40'h12345_6789A;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_rk",    64'(rk),       64'd0);
    check("reset_valid", 64'(rk_valid), 64'd0);
    check("reset_idx",   64'(rk_idx),   64'd0);
    check("reset_last",  64'(rk_last),  64'd0);
    check("reset_busy",  64'(busy),     64'd0);
    check("reset_done",  64'(done),     64'd0);
    rst  = 1'b0;
    load = 1'b0;

    // Simple ascending key, full 32-round run.
    run({10'h004, 10'h003, 10'h002, 10'h001}, -1, 0, -1, -1, 1'b0);
    // All-zero key loaded in the done cycle; idx 4 must be 0x3FD.
    run(40'd0, -1, 0, -1, -1, 1'b0);
    check("zero_idx4", 64'(exp_rk[4]), 64'h3FD);

    // Idle: done drops, rk_ready has no effect.
    @(posedge clk); #1;
    rk_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_done",  64'(done),     64'd0);
      check("idle_valid", 64'(rk_valid), 64'd0);
      check("idle_busy",  64'(busy),     64'd0);
    end

    run(40'({$urandom(), $urandom()}), 5, 3, -1, -1, 1'b0);
    run(40'({$urandom(), $urandom()}), -1, 0, 7, -1, 1'b0);
    run(40'({$urandom(), $urandom()}), -1, 0, -1, 10, 1'b0);
    for (int r = 0; r < 4; r++) run(40'({$urandom(), $urandom()}), -1, 0, -1, -1, 1'b1);

    @(posedge clk); #1;
    @(negedge clk);
    check("final_done", 64'(done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
